// File: rtl/ksa_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : ksa_pipe
//  Description : Parametrised pipelined Kogge-Stone adder/subtractor with
//                carry-in, subtract mode, signed-overflow flag and
//                valid/ready flow control. An input register is followed by
//                ceil(log2(WIDTH)) prefix levels, with a register after every
//                PIPE_STRIDE levels, then the sum/output register.
//  Revision    : 1.0 - initial release
// ============================================================================
module ksa_pipe #(
  parameter int WIDTH       = 48,
  parameter int PIPE_STRIDE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  output logic             out_ovf
);

  localparam int LEVELS  = $clog2(WIDTH);
  localparam int LATENCY = 2 + (LEVELS - 1) / PIPE_STRIDE;

  logic             w_stall;
  logic [WIDTH-1:0] w_beff, w_pin, w_gin;
  logic             w_cin0;
  logic [WIDTH-1:0] r_g0, r_p0;
  logic             r_c0;
  // One valid bit per register stage ahead of the output register.
  logic [LATENCY-2:0] r_vld;
  logic             r_out_valid;
  logic [WIDTH:0]   r_out_sum;
  logic             r_out_ovf;
  logic [WIDTH-1:0] w_gf, w_p0f, w_carry, w_sum;
  logic             w_c0f;
  logic             w_unused_pf;

  // The whole pipeline advances as one: any output stall freezes every stage.
  assign w_stall   = r_out_valid & ~out_ready;
  assign in_ready  = rst_n & ~w_stall;
  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_ovf   = r_out_ovf;

  // Operand conditioning: subtraction is A + ~B + 1, carry-in folded into G[0].
  always_comb begin
    w_beff   = in_sub ? ~in_b : in_b;
    w_cin0   = in_sub | in_cin;
    w_pin    = in_a ^ w_beff;
    w_gin    = in_a & w_beff;
    w_gin[0] = w_gin[0] | (w_pin[0] & w_cin0);
  end

  // Valid bits shift with the data; a non-valid input inserts a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
    end else if (!w_stall) begin
      r_vld[0] <= in_valid;
      for (int j = 1; j < LATENCY - 1; j++) begin
        r_vld[j] <= r_vld[j-1];
      end
    end
  end

  // Input data register; contents are qualified by r_vld so no reset needed.
  always_ff @(posedge clk) begin
    if (!w_stall) begin
      r_g0 <= w_gin;
      r_p0 <= w_pin;
      r_c0 <= w_cin0;
    end
  end

  for (genvar k = 1; k <= LEVELS; k++) begin : g_level
    localparam int D = 1 << (k - 1);
    logic [WIDTH-1:0] w_gi, w_pi, w_p0i, w_gn, w_pn, w_go, w_po, w_p0o;
    logic             w_c0i, w_c0o;

    if (k == 1) begin : g_from_input
      assign w_gi  = r_g0;
      assign w_pi  = r_p0;
      assign w_p0i = r_p0;
      assign w_c0i = r_c0;
    end else begin : g_from_prev
      assign w_gi  = g_level[k-1].w_go;
      assign w_pi  = g_level[k-1].w_po;
      assign w_p0i = g_level[k-1].w_p0o;
      assign w_c0i = g_level[k-1].w_c0o;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i >= D) begin : g_merge
        assign w_gn[i] = w_gi[i] | (w_pi[i] & w_gi[i-D]);
        assign w_pn[i] = w_pi[i] & w_pi[i-D];
      end else begin : g_pass
        assign w_gn[i] = w_gi[i];
        assign w_pn[i] = w_pi[i];
      end
    end

    if (((k % PIPE_STRIDE) == 0) && (k < LEVELS)) begin : g_reg
      logic [WIDTH-1:0] r_g, r_p, r_p0s;
      logic             r_c0s;
      // Mid-prefix pipeline register, frozen together with the rest on stall.
      always_ff @(posedge clk) begin
        if (!w_stall) begin
          r_g   <= w_gn;
          r_p   <= w_pn;
          r_p0s <= w_p0i;
          r_c0s <= w_c0i;
        end
      end
      assign w_go  = r_g;
      assign w_po  = r_p;
      assign w_p0o = r_p0s;
      assign w_c0o = r_c0s;
    end else begin : g_wire
      assign w_go  = w_gn;
      assign w_po  = w_pn;
      assign w_p0o = w_p0i;
      assign w_c0o = w_c0i;
    end
  end

  // Group propagate after the last level has no consumer.
  assign w_unused_pf = ^g_level[LEVELS].w_po;

  // Final carries: G after the last level is the carry out of each bit.
  always_comb begin
    w_gf    = g_level[LEVELS].w_go;
    w_p0f   = g_level[LEVELS].w_p0o;
    w_c0f   = g_level[LEVELS].w_c0o;
    w_carry = {w_gf[WIDTH-2:0], w_c0f};
    w_sum   = w_p0f ^ w_carry;
  end

  // Output register: sum, carry-out and overflow; holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_ovf   <= 1'b0;
    end else if (!w_stall) begin
      r_out_valid <= r_vld[LATENCY-2];
      r_out_sum   <= {w_gf[WIDTH-1], w_sum};
      r_out_ovf   <= w_carry[WIDTH-1] ^ w_gf[WIDTH-1];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ksa_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ksa_pipe
//  Description : Self-checking bench for ksa_pipe: directed vector table,
//                backpressure stream, mid-flight reset, and a width/stride
//                sweep on three extra instances.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ksa_pipe;

  localparam int W    = 48;
  localparam int LAT  = 4;
  localparam int NSW  = 1000;
  localparam int LAT8 = 4;   // WIDTH 8,  stride 1: L=3
  localparam int LAT33 = 2;  // WIDTH 33, stride 6: L=6
  localparam int LAT64 = 7;  // WIDTH 64, stride 1: L=6

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, in_valid, in_cin, in_sub, out_ready;
  logic [W-1:0]  in_a, in_b;
  logic          in_ready, out_valid, out_ovf;
  logic [W:0]    out_sum;

  ksa_pipe #(.WIDTH(W), .PIPE_STRIDE(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_ovf(out_ovf)
  );

  // Sweep instances share one stimulus stream, truncated per width.
  logic        sw_valid, sw_sub;
  logic [63:0] sw_a, sw_b;
  logic        r8, r33, r64, v8, v33, v64, f8, f33, f64;
  logic [8:0]  s8;
  logic [33:0] s33;
  logic [64:0] s64;

  ksa_pipe #(.WIDTH(8), .PIPE_STRIDE(1)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(r8),
    .in_a(sw_a[7:0]), .in_b(sw_b[7:0]), .in_cin(1'b1), .in_sub(sw_sub),
    .out_valid(v8), .out_ready(1'b1), .out_sum(s8), .out_ovf(f8)
  );
  ksa_pipe #(.WIDTH(33), .PIPE_STRIDE(6)) u_w33 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(r33),
    .in_a(sw_a[32:0]), .in_b(sw_b[32:0]), .in_cin(1'b1), .in_sub(sw_sub),
    .out_valid(v33), .out_ready(1'b1), .out_sum(s33), .out_ovf(f33)
  );
  ksa_pipe #(.WIDTH(64), .PIPE_STRIDE(1)) u_w64 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(r64),
    .in_a(sw_a), .in_b(sw_b), .in_cin(1'b1), .in_sub(sw_sub),
    .out_valid(v64), .out_ready(1'b1), .out_sum(s64), .out_ovf(f64)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W:0]   sum;
    logic         ovf;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference for the 48-bit instance: plain integer addition.
  function automatic logic [W+1:0] model48(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin, input logic sub);
    logic [W-1:0] be;
    logic [W:0]   s;
    logic         ov;
    be = sub ? ~b : b;
    s  = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, (sub | cin)};
    ov = (a[W-1] == be[W-1]) && (s[W-1] != a[W-1]);
    return {ov, s};
  endfunction

  // Reference for sweep instances (carry-in fixed at 1): {ovf, sum[64:0]}.
  function automatic logic [65:0] model_w(input logic [63:0] a, input logic [63:0] b,
                                          input logic sub, input int w);
    logic [63:0] mask, am, bm;
    logic [64:0] s;
    logic        ov;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    am   = a & mask;
    bm   = (sub ? ~b : b) & mask;
    s    = {1'b0, am} + {1'b0, bm} + 65'd1;
    ov   = (am[w-1] == bm[w-1]) && (s[w-1] != am[w-1]);
    return {ov, s};
  endfunction

  // Single beat through an empty pipeline: latency, sum and overflow.
  task automatic run_vec(input vec_t v, input string tag);
    int cyc;
    in_a = v.a; in_b = v.b; in_cin = v.cin; in_sub = v.sub; in_valid = 1'b1;
    #1;
    check({tag, "_ready"}, in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      step();
      cyc++;
    end
    check({tag, "_latency"}, cyc, LAT);
    check({tag, "_sum"}, out_sum, v.sum);
    check({tag, "_ovf"}, out_ovf, v.ovf);
    step();
  endtask

  logic [W-1:0] ba[10], bb[10];
  logic         bcin[10], bsub[10];
  logic [W+1:0] expq[$];
  logic [W+1:0] held;
  logic [63:0]  sa[NSW], sb[NSW];
  logic         ss[NSW];

  initial begin
    int nsent, nrecv, cyc;
    logic was_stall, seen;

    vecs[0] = '{48'hFFFF_FFFF_FFFF, 48'h1, 1'b0, 1'b0, 49'h1_0000_0000_0000, 1'b0};
    vecs[1] = '{48'h5, 48'h7, 1'b0, 1'b1, 49'h0_FFFF_FFFF_FFFE, 1'b0};
    vecs[2] = '{48'h7, 48'h5, 1'b0, 1'b1, 49'h1_0000_0000_0002, 1'b0};
    vecs[3] = '{48'h7FFF_FFFF_FFFF, 48'h1, 1'b0, 1'b0, 49'h0_8000_0000_0000, 1'b1};
    vecs[4] = '{48'h8000_0000_0000, 48'h8000_0000_0000, 1'b0, 1'b0, 49'h1_0000_0000_0000, 1'b1};
    vecs[5] = '{48'h0, 48'h0, 1'b1, 1'b0, 49'h0_0000_0000_0001, 1'b0};
    vecs[6] = '{48'hA, 48'h3, 1'b1, 1'b1, 49'h1_0000_0000_0007, 1'b0};
    vecs[7] = '{48'h8000_0000_0000, 48'h1, 1'b0, 1'b1, 49'h1_7FFF_FFFF_FFFF, 1'b1};
    vecs[8] = '{48'h1234_5678_9ABC, 48'h1111_1111_1111, 1'b1, 1'b0, 49'h0_2345_6789_ABCE, 1'b0};

    rst_n = 1'b1; in_valid = 1'b0; in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0;
    sw_valid = 1'b0; sw_sub = 1'b0; sw_a = '0; sw_b = '0;

    // Reset state
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_sum", out_sum, '0);
    check("rst_out_ovf", out_ovf, 1'b0);
    rst_n = 1'b1;
    #1;
    check("rst_release_ready", in_ready, 1'b1);

    // Directed table
    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Backpressure stream against a queue model
    for (int i = 0; i < 10; i++) begin
      ba[i] = {$urandom, $urandom};
      bb[i] = {$urandom, $urandom};
      bcin[i] = 1'($urandom_range(0, 1));
      bsub[i] = 1'($urandom_range(0, 1));
    end
    nsent = 0; nrecv = 0; was_stall = 1'b0; held = '0;
    for (int c = 0; c < 300 && nrecv < 10; c++) begin
      out_ready = (((c / 3) % 2) == 1);
      if (nsent < 10) begin
        in_valid = 1'b1; in_a = ba[nsent]; in_b = bb[nsent];
        in_cin = bcin[nsent]; in_sub = bsub[nsent];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (was_stall) check("bp_stable", {out_ovf, out_sum}, held);
      check("bp_ready", in_ready, !(out_valid && !out_ready));
      if (out_valid && out_ready) begin
        if (expq.size() == 0) check("bp_extra_beat", 1'b1, 1'b0);
        else check("bp_data", {out_ovf, out_sum}, expq.pop_front());
        nrecv++;
      end
      was_stall = out_valid && !out_ready;
      held = {out_ovf, out_sum};
      if (in_valid && in_ready) begin
        expq.push_back(model48(in_a, in_b, in_cin, in_sub));
        nsent++;
      end
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("bp_recv_count", nrecv, 10);
    check("bp_queue_empty", expq.size(), 0);
    step();

    // Reset with beats in flight
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_a = ba[i]; in_b = bb[i]; in_cin = 1'b0; in_sub = 1'b0;
      step();
    end
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 10) begin
      step();
      cyc++;
    end
    check("mid_pre_valid", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_sum", out_sum, '0);
    check("mid_rst_ready", in_ready, 1'b0);
    @(posedge clk);
    #3;
    check("mid_rst_ready_held", in_ready, 1'b0);
    rst_n = 1'b1;
    #1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    check("mid_no_ghost", seen, 1'b0);
    run_vec(vecs[2], "mid_post");

    // Width / stride sweep, streaming one beat per cycle
    for (int i = 0; i < NSW; i++) begin
      sa[i] = {$urandom, $urandom};
      sb[i] = {$urandom, $urandom};
      ss[i] = 1'($urandom_range(0, 1));
    end
    for (int c = 0; c < NSW + 10; c++) begin
      if (c < NSW) begin
        sw_valid = 1'b1; sw_a = sa[c]; sw_b = sb[c]; sw_sub = ss[c];
      end else begin
        sw_valid = 1'b0;
      end
      #1;
      if (c >= LAT8 && c - LAT8 < NSW)
        check("w8_beat", {v8, f8, 56'd0, s8}, {1'b1, model_w(sa[c-LAT8], sb[c-LAT8], ss[c-LAT8], 8)});
      else
        check("w8_idle", v8, 1'b0);
      if (c >= LAT33 && c - LAT33 < NSW)
        check("w33_beat", {v33, f33, 31'd0, s33}, {1'b1, model_w(sa[c-LAT33], sb[c-LAT33], ss[c-LAT33], 33)});
      else
        check("w33_idle", v33, 1'b0);
      if (c >= LAT64 && c - LAT64 < NSW)
        check("w64_beat", {v64, f64, s64}, {1'b1, model_w(sa[c-LAT64], sb[c-LAT64], ss[c-LAT64], 64)});
      else
        check("w64_idle", v64, 1'b0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
